// File: rtl/ducks_pkg.sv
// Shared constants and types for the duck-hunt video pipeline.
// Screen geometry, palette and the projectile controller state encoding.
package ducks_pkg;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned GUN_TOP    = 466;
    localparam int unsigned GUN_W      = 94;
    localparam int unsigned BARREL_OFS = 45;

    localparam logic [5:0] COL_BULLET = 6'h3F;
    localparam logic [5:0] COL_FLASH  = 6'h30;
    localparam logic [5:0] COL_AMMO   = 6'h3C;

    localparam int unsigned ICON_X0    = 8;
    localparam int unsigned ICON_Y0    = 8;
    localparam int unsigned ICON_PITCH = 12;
    localparam int unsigned ICON_SIZE  = 8;

    typedef enum logic [1:0] {
        StReady,
        StFlying,
        StHitFlash,
        StEmpty
    } shot_state_e;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle intersection test.
// Sums are done in 11 bits so right/bottom edges near 1023 never wrap.
module rect_overlap #(
    parameter int unsigned A_W = 1,
    parameter int unsigned A_H = 1,
    parameter int unsigned B_W = 1,
    parameter int unsigned B_H = 1
) (
    input  logic [9:0] a_x_i,
    input  logic [9:0] a_y_i,
    input  logic [9:0] b_x_i,
    input  logic [9:0] b_y_i,
    output logic       overlap_o
);

    logic [10:0] ax, ay, bx, by;

    assign ax = {1'b0, a_x_i};
    assign ay = {1'b0, a_y_i};
    assign bx = {1'b0, b_x_i};
    assign by = {1'b0, b_y_i};

    assign overlap_o = (ax <= bx + 11'(B_W - 1)) && (bx <= ax + 11'(A_W - 1)) &&
                       (ay <= by + 11'(B_H - 1)) && (by <= ay + 11'(A_H - 1));

endmodule

// File: rtl/gun_shot.sv
// Bullet launch, flight, duck hit detection and ammo bookkeeping, plus the
// registered bullet / hit-flash / ammo-icon pixel overlay.
module gun_shot
    import ducks_pkg::*;
#(
    parameter int unsigned BULLET_W     = 4,
    parameter int unsigned BULLET_H     = 8,
    parameter int unsigned SPEED        = 4,
    parameter int unsigned DUCK_W       = 32,
    parameter int unsigned DUCK_H       = 32,
    parameter int unsigned AMMO         = 3,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       fire,
    input  logic       reload,
    input  logic [9:0] gun_x,
    input  logic [9:0] duck_x,
    input  logic [9:0] duck_y,
    input  logic       duck_alive,
    output logic [5:0] data,
    output logic       draw,
    output logic       hit,
    output logic       shot_active,
    output logic [1:0] ammo
);

    shot_state_e state_q;
    logic [9:0]  bx_q, by_q;
    logic [1:0]  ammo_q;
    logic [7:0]  flash_cnt_q;
    logic        fire_q, check_q, hit_q, draw_q;
    logic [5:0]  data_q;

    logic        tick, fire_edge, duck_ovl, pix_in_bullet, icon_hit;
    logic [1:0]  ammo_avail;
    shot_state_e idle_state;

    assign tick       = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
    assign fire_edge  = fire & ~fire_q;
    // Reload is applied before anything else looks at the ammo count.
    assign ammo_avail = reload ? 2'(AMMO) : ammo_q;
    assign idle_state = (ammo_avail == 2'd0) ? StEmpty : StReady;

    rect_overlap #(
        .A_W(BULLET_W),
        .A_H(BULLET_H),
        .B_W(DUCK_W),
        .B_H(DUCK_H)
    ) u_duck_ovl (
        .a_x_i    (bx_q),
        .a_y_i    (by_q),
        .b_x_i    (duck_x),
        .b_y_i    (duck_y),
        .overlap_o(duck_ovl)
    );

    rect_overlap #(
        .A_W(BULLET_W),
        .A_H(BULLET_H),
        .B_W(1),
        .B_H(1)
    ) u_pix_ovl (
        .a_x_i    (bx_q),
        .a_y_i    (by_q),
        .b_x_i    (hcount),
        .b_y_i    (vcount),
        .overlap_o(pix_in_bullet)
    );

    always_comb begin
        icon_hit = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if ((2'(i) < ammo_q) &&
                (hcount >= 10'(ICON_X0 + ICON_PITCH * i)) &&
                (hcount <= 10'(ICON_X0 + ICON_PITCH * i + ICON_SIZE - 1)) &&
                (vcount >= 10'(ICON_Y0)) && (vcount <= 10'(ICON_Y0 + ICON_SIZE - 1))) begin
                icon_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StReady;
            bx_q        <= '0;
            by_q        <= '0;
            ammo_q      <= 2'(AMMO);
            flash_cnt_q <= '0;
            fire_q      <= 1'b1;
            check_q     <= 1'b0;
            hit_q       <= 1'b0;
            draw_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            fire_q  <= fire;
            hit_q   <= 1'b0;
            check_q <= 1'b0;
            ammo_q  <= ammo_avail;

            unique case (state_q)
                StReady, StEmpty: begin
                    if (fire_edge && (state_q == StReady || reload)) begin
                        bx_q    <= gun_x + 10'(BARREL_OFS);
                        by_q    <= 10'(GUN_TOP - BULLET_H);
                        ammo_q  <= ammo_avail - 2'd1;
                        state_q <= StFlying;
                    end else if (reload) begin
                        state_q <= StReady;
                    end
                end
                StFlying: begin
                    // The compare runs the cycle after a move; a hit outranks a tick.
                    if (check_q && duck_alive && duck_ovl) begin
                        hit_q       <= 1'b1;
                        flash_cnt_q <= '0;
                        state_q     <= StHitFlash;
                    end else if (tick) begin
                        if (by_q < 10'(SPEED)) begin
                            state_q <= idle_state;
                        end else begin
                            by_q    <= by_q - 10'(SPEED);
                            check_q <= 1'b1;
                        end
                    end
                end
                StHitFlash: begin
                    if (tick) begin
                        if (flash_cnt_q == 8'(FLASH_FRAMES - 1)) begin
                            state_q <= idle_state;
                        end else begin
                            flash_cnt_q <= flash_cnt_q + 8'd1;
                        end
                    end
                end
            endcase

            if (state_q == StFlying && pix_in_bullet) begin
                draw_q <= 1'b1;
                data_q <= COL_BULLET;
            end else if (state_q == StHitFlash && !flash_cnt_q[1] && pix_in_bullet) begin
                draw_q <= 1'b1;
                data_q <= COL_FLASH;
            end else if (icon_hit) begin
                draw_q <= 1'b1;
                data_q <= COL_AMMO;
            end else begin
                draw_q <= 1'b0;
            end
        end
    end

    assign data        = data_q;
    assign draw        = draw_q;
    assign hit         = hit_q;
    assign shot_active = (state_q == StFlying);
    assign ammo        = ammo_q;

endmodule

// File: tb/tb_gun_shot.sv
// Directed bench for gun_shot: expectations are queued as stimulus is applied
// and popped in order as the DUT outputs are sampled.
module tb_gun_shot;

    logic       clk = 1'b0;
    logic       reset, fire, reload, duck_alive;
    logic [9:0] hcount, vcount, gun_x, duck_x, duck_y;
    logic [5:0] data;
    logic       draw, hit, shot_active;
    logic [1:0] ammo;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          hit_cnt  = 0;

    gun_shot u_dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .fire       (fire),
        .reload     (reload),
        .gun_x      (gun_x),
        .duck_x     (duck_x),
        .duck_y     (duck_y),
        .duck_alive (duck_alive),
        .data       (data),
        .draw       (draw),
        .hit        (hit),
        .shot_active(shot_active),
        .ammo       (ammo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (hit === 1'b1) hit_cnt <= hit_cnt + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_raster();
        hcount = 10'd1;
        vcount = 10'd500;
    endtask

    // One frame tick followed by one quiet cycle for the post-move compare.
    task automatic tick();
        hcount = 10'd0;
        vcount = 10'd480;
        cyc();
        idle_raster();
        cyc();
    endtask

    task automatic want(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        hcount = x;
        vcount = y;
        cyc();
        idle_raster();
    endtask

    initial begin
        reset = 1'b1; fire = 1'b1; reload = 1'b0; duck_alive = 1'b0;
        gun_x = 10'd289; duck_x = 10'd0; duck_y = 10'd0;
        idle_raster();
        repeat (3) cyc();

        // Reset released with fire held: no shot
        reset = 1'b0;
        want(0); want(3); want(0); want(0); want(0);
        cyc();
        check("rst_shot_active", 32'(shot_active));
        check("rst_ammo", 32'(ammo));
        check("rst_draw", 32'(draw));
        check("rst_hit", 32'(hit));
        check("rst_data", 32'(data));
        want(0);
        repeat (3) cyc();
        check("held_fire_no_shot", 32'(shot_active));

        // Fresh press launches a bullet
        fire = 1'b0;
        cyc();
        fire = 1'b1;
        want(1); want(2);
        cyc();
        check("fire_shot_active", 32'(shot_active));
        check("fire_ammo", 32'(ammo));
        fire = 1'b0;
        want(1); want(32'h3F);
        probe(10'd334, 10'd458);
        check("launch_draw", 32'(draw));
        check("launch_data", 32'(data));
        want(0);
        probe(10'd333, 10'd458);
        check("left_of_bullet", 32'(draw));

        // First tick moves to y=454
        tick();
        want(1); want(32'h3F);
        probe(10'd334, 10'd454);
        check("tick1_draw", 32'(draw));
        check("tick1_data", 32'(data));
        want(0); want(32'h3F);
        probe(10'd334, 10'd453);
        check("above_bullet", 32'(draw));
        check("data_holds", 32'(data));
        want(1);
        probe(10'd337, 10'd461);
        check("bullet_corner", 32'(draw));
        want(0);
        probe(10'd338, 10'd454);
        check("right_of_bullet", 32'(draw));

        // Miss on tick 115
        for (int i = 2; i <= 114; i++) tick();
        want(1);
        check("still_flying_114", 32'(shot_active));
        tick();
        want(0); want(2); want(0);
        check("miss_ready", 32'(shot_active));
        check("miss_ammo", 32'(ammo));
        check("miss_no_hit", 32'(hit_cnt));

        // Duck at (330,300): hit two cycles after tick 32
        duck_alive = 1'b1; duck_x = 10'd330; duck_y = 10'd300;
        fire = 1'b1;
        cyc();
        fire = 1'b0;
        cyc();
        for (int i = 1; i <= 31; i++) tick();
        want(0);
        check("no_hit_before_32", 32'(hit_cnt));
        hcount = 10'd0; vcount = 10'd480;
        cyc();
        idle_raster();
        want(0);
        check("hit_t_plus_1", 32'(hit));
        cyc();
        want(1);
        check("hit_t_plus_2", 32'(hit));
        cyc();
        want(0); want(0); want(1);
        check("hit_one_cycle", 32'(hit));
        check("flash_not_active", 32'(shot_active));
        check("hit_count", 32'(hit_cnt));
        want(1); want(32'h30);
        probe(10'd334, 10'd330);
        check("flash_draw", 32'(draw));
        check("flash_data", 32'(data));

        // Flash spans 8 ticks; fire during flash is dropped
        duck_alive = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        fire = 1'b1;
        cyc();
        want(0); want(1);
        check("fire_in_flash_dropped", 32'(shot_active));
        check("flash_ammo", 32'(ammo));
        fire = 1'b0;
        cyc();
        tick();
        fire = 1'b1;
        cyc();
        want(1); want(0);
        check("ready_after_flash", 32'(shot_active));
        check("last_shot_ammo", 32'(ammo));
        fire = 1'b0;

        // Bullet misses into EMPTY; further fire ignored
        for (int i = 1; i <= 115; i++) tick();
        fire = 1'b1;
        cyc();
        want(0); want(0);
        check("empty_ignores_fire", 32'(shot_active));
        check("empty_ammo", 32'(ammo));
        fire = 1'b0;
        cyc();
        want(0);
        probe(10'd8, 10'd8);
        check("no_icon_when_empty", 32'(draw));

        // Reload from EMPTY
        reload = 1'b1;
        cyc();
        reload = 1'b0;
        want(3); want(0);
        check("reload_ammo", 32'(ammo));
        check("reload_not_flying", 32'(shot_active));
        want(1); want(32'h3C);
        probe(10'd8, 10'd8);
        check("icon0_draw", 32'(draw));
        check("icon0_data", 32'(data));
        want(1);
        probe(10'd39, 10'd15);
        check("icon2_corner", 32'(draw));
        want(0);
        probe(10'd16, 10'd8);
        check("icon_gap", 32'(draw));
        want(0);
        probe(10'd44, 10'd8);
        check("no_icon3", 32'(draw));
        fire = 1'b1;
        cyc();
        fire = 1'b0;
        want(1); want(2);
        check("ready_after_reload", 32'(shot_active));
        check("ammo_after_reload_fire", 32'(ammo));
        reload = 1'b1;
        cyc();
        reload = 1'b0;
        want(1); want(3);
        check("reload_keeps_flight", 32'(shot_active));
        check("reload_in_flight_ammo", 32'(ammo));

        // Reset mid-flight
        reset = 1'b1;
        hcount = 10'd334; vcount = 10'd458;
        cyc();
        reset = 1'b0;
        idle_raster();
        want(0); want(0); want(3);
        check("midflight_rst_draw", 32'(draw));
        check("midflight_rst_active", 32'(shot_active));
        check("midflight_rst_ammo", 32'(ammo));
        cyc();

        // Reload and fire edge on the same cycle
        fire = 1'b1; reload = 1'b1;
        cyc();
        fire = 1'b0; reload = 1'b0;
        want(1); want(2); want(1);
        check("reload_fire_active", 32'(shot_active));
        check("reload_fire_ammo", 32'(ammo));
        cyc();
        check("total_hits", 32'(hit_cnt));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gun_shot.md
# gun_shot

Projectile and ammunition controller for the duck-hunt video pipeline. Consumes the player's `fire` button and the gun's horizontal position, launches a bullet from the gun barrel, advances it upward once per frame, and tests it against the duck bounding box. Emits per-pixel `draw`/`data` on the same hcount/vcount raster as the gun sprite, a one-cycle `hit` pulse to the duck/score logic, and the remaining ammunition count.

## Interface
Parameters:
- `BULLET_W`, 4: bullet width, px
- `BULLET_H`, 8: bullet height, px
- `SPEED`, 4: px moved per frame
- `DUCK_W`, 32: duck box width, px
- `DUCK_H`, 32: duck box height, px
- `AMMO`, 3: shots per load, legal 1..3
- `FLASH_FRAMES`, 8: hit-flash duration, frames

Ports (reset `reset`, synchronous, active-high; clock `clk`):
- `clk` in 1: pixel clock
- `reset` in 1: synchronous, active-high
- `hcount` in 10: raster column
- `vcount` in 10: raster line
- `fire` in 1: fire button, level, already synchronized
- `reload` in 1: refill ammo, level
- `gun_x` in 10: gun sprite left edge, px
- `duck_x` in 10: duck box left edge
- `duck_y` in 10: duck box top edge
- `duck_alive` in 1: duck targetable
- `data` out 6: pixel colour
- `draw` out 1: this module owns the pixel
- `hit` out 1: one-cycle hit pulse
- `shot_active` out 1: bullet in flight
- `ammo` out 2: shots remaining

## Operation
- Frame tick: internal one-cycle strobe when `hcount==0 && vcount==480`. All motion and frame counting happen only on the tick.
- Fire edge: `fire & ~fire_q`; `fire_q` resets to 1, so a button held through reset does not shoot. Held fire yields one shot.
- States: READY, FLYING, HIT_FLASH, EMPTY.
- READY + fire edge: capture `bx = gun_x + 45`, `by = 458`; `ammo -= 1`; go FLYING.
- FLYING, on tick: if `by < SPEED`, miss, go READY (EMPTY if `ammo==0`); else `by -= SPEED`.
- Cycle after each FLYING move: rect_overlap test of bullet `[bx,bx+BW-1]×[by,by+BH-1]` against duck `[duck_x,duck_x+DW-1]×[duck_y,duck_y+DH-1]`, gated by `duck_alive`. On overlap: `hit=1` for exactly that cycle; bullet frozen; flash counter cleared; go HIT_FLASH.
- HIT_FLASH: count ticks; after `FLASH_FRAMES` ticks go READY (EMPTY if `ammo==0`).
- EMPTY: fire ignored.
- `reload` (any state): `ammo := AMMO`; EMPTY→READY; flight or flash continues unaffected.
- Reload and fire edge in the same cycle: reload first, then fire is accepted (`ammo` becomes AMMO-1).
- Fire edge during FLYING/HIT_FLASH: dropped, not queued.
- Drawing, registered (output reflects the hcount/vcount of the previous cycle):
  - Bullet pixel in FLYING: `data=6'h3F`.
  - In HIT_FLASH when `flash_cnt[1]==0`: `data=6'h30`.
  - Ammo icons: for i<ammo, 8×8 squares at x `8+12i..15+12i`, y `8..15`, `data=6'h3C`.
  - Otherwise `draw=0`, `data` holds.
- Arithmetic: all overlap sums in 11 bits, so `duck_x+DUCK_W-1` near 1023 cannot wrap.
- `shot_active = (state==FLYING)`.

## Timing
- Reset values: `data=0`, `draw=0`, `hit=0`, `shot_active=0`, `ammo=AMMO`, state READY, `bx=by=0`, `flash_cnt=0`.
- Reset mid-flight or mid-flash: next cycle in READY with full ammo, nothing drawn.
- Fire edge to `shot_active=1`: 1 cycle. First move occurs on the next tick.
- Tick to `hit`: 2 cycles (move, then compare).
- `draw`/`data` latency: 1 cycle after hcount/vcount.

## Structure
- Shared `ducks_pkg` holds: screen constants (H_ACTIVE 640, V_ACTIVE 480, GUN_TOP 466, GUN_W 94, BARREL_OFS 45), colour constants, and the state enum.
- Sub-module `rect_overlap` (combinational, 11-bit, parameterized widths/heights), reused by the duck and score logic.

## Test plan
- Reset with `fire` held high, then release and press again: no shot on reset release; the press gives `shot_active=1`, `ammo` 3→2, bullet at x=334, y=458 for `gun_x=289`.
- `duck_alive=0`, one shot: y=454 after tick 1; on tick 115 state returns to READY, `shot_active=0`, no `hit`.
- Duck at (330,300), `gun_x=289`: `hit` pulses once, 1 cycle, 2 cycles after tick 32 (by=330); flash lasts 8 ticks, then READY.
- Three shots to EMPTY: fourth edge ignored; `reload` gives `ammo=3` and READY. Reload and fire on the same cycle gives `ammo=2` and FLYING.
- Raster check: in FLYING at (334,454), `draw=1`, `data=3F` one cycle after hcount=334, vcount=454. Ammo icon pixel (8,8) draws with `data=3C` only while `ammo≥1`.
- Reset asserted mid-flight: next cycle `draw=0`, `shot_active=0`, `ammo=3`.
